// File: rtl/mc_bus_bridge.sv
// mc_bus_bridge: MCU async-strobe bus to register-file write FIFO, with an optional
// readback path compiled in by MC_READBACK_EN.
module mc_bus_bridge #(
   parameter int MC_ADD_WIDTH  = 6,
   parameter int MC_DATA_WIDTH = 16,
   parameter int FIFO_DEPTH    = 4,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          mc_ce_n,
   input  logic                          mc_we_n,
   input  logic                          mc_oe_n,
   input  logic [MC_ADD_WIDTH-1:0]       mc_add,
   input  logic [MC_DATA_WIDTH-1:0]      mc_data_in,
   output logic [MC_DATA_WIDTH-1:0]      mc_data_out,
   output logic                          mc_data_oe,
   output logic                          wr_valid,
   input  logic                          wr_ready,
   output logic [MC_ADD_WIDTH-1:0]       wr_addr,
   output logic [MC_DATA_WIDTH-1:0]      wr_data,
   output logic [MC_ADD_WIDTH-1:0]       rd_addr,
   input  logic [MC_DATA_WIDTH-1:0]      rd_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int EW = MC_ADD_WIDTH + MC_DATA_WIDTH;
   logic [SYNC_STAGES-1:0]   ce_q, we_q;
   logic [MC_ADD_WIDTH-1:0]  add_q;
   logic [MC_DATA_WIDTH-1:0] data_q;
   logic                     wact_q, overflow_q;
   logic [EW-1:0]            mem_q [FIFO_DEPTH];
   logic [PW-1:0]            wptr_q, rptr_q;
   logic [LW-1:0]            level_q, level_d;
   logic                     ce_s, we_s, wact, wrise, full, pop, push;
   assign ce_s    = ce_q[SYNC_STAGES-1];
   assign we_s    = we_q[SYNC_STAGES-1];
   assign wact    = ~ce_s & ~we_s;
   assign wrise   = wact & ~wact_q;
   assign full    = level_q == LW'(FIFO_DEPTH);
   assign pop     = wr_valid & wr_ready;
   assign push    = wrise & (~full | pop);
   assign level_d = level_q + LW'(push) - LW'(pop);
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         ce_q       <= '1;
         we_q       <= '1;
         add_q      <= '0;
         data_q     <= '0;
         wact_q     <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         ce_q       <= {ce_q[SYNC_STAGES-2:0], mc_ce_n};
         we_q       <= {we_q[SYNC_STAGES-2:0], mc_we_n};
         add_q      <= mc_add;
         data_q     <= mc_data_in;
         wact_q     <= wact;
         wptr_q     <= push ? wptr_q + PW'(1) : wptr_q;
         rptr_q     <= pop ? rptr_q + PW'(1) : rptr_q;
         level_q    <= level_d;
         overflow_q <= overflow_q | (wrise & full & ~pop);
      end
   always_ff @(posedge clock)
      if (push) mem_q[wptr_q] <= {add_q, data_q};
   // head is gated so stale or uninitialised entries never leak onto the outputs
   assign wr_valid            = level_q != '0;
   assign {wr_addr, wr_data}  = wr_valid ? mem_q[rptr_q] : '0;
   assign fifo_level          = level_q;
   assign overflow            = overflow_q;
`ifdef MC_READBACK_EN
   typedef enum logic [1:0] {IDLE, LATCH, DRIVE} rd_state_e;
   rd_state_e                state_q, state_d;
   logic [SYNC_STAGES-1:0]   oe_q;
   logic                     ract, ract_q, rrise;
   logic [MC_ADD_WIDTH-1:0]  rd_addr_q, rd_addr_d;
   logic [MC_DATA_WIDTH-1:0] dout_q, dout_d;
   logic                     doe_q, doe_d;
   assign ract  = ~ce_s & ~oe_q[SYNC_STAGES-1] & we_s;
   assign rrise = ract & ~ract_q;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state_q   <= IDLE;
         oe_q      <= '1;
         ract_q    <= 1'b0;
         rd_addr_q <= '0;
         dout_q    <= '0;
         doe_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         oe_q      <= {oe_q[SYNC_STAGES-2:0], mc_oe_n};
         ract_q    <= ract;
         rd_addr_q <= rd_addr_d;
         dout_q    <= dout_d;
         doe_q     <= doe_d;
      end
   // a write edge aborts any read in progress
   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      dout_d    = dout_q;
      doe_d     = doe_q;
      if (state_q != IDLE && wrise) begin
         doe_d   = 1'b0;
         state_d = IDLE;
      end else
         case (state_q)
            IDLE: if (rrise) begin
               rd_addr_d = add_q;
               state_d   = LATCH;
            end
            LATCH: begin
               dout_d  = rd_data;
               doe_d   = 1'b1;
               state_d = DRIVE;
            end
            DRIVE: if (!ract) begin
               doe_d   = 1'b0;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
   end
   assign rd_addr     = rd_addr_q;
   assign mc_data_out = dout_q;
   assign mc_data_oe  = doe_q;
`else
   logic unused_rd;
   assign unused_rd   = ^{mc_oe_n, rd_data};
   assign rd_addr     = '0;
   assign mc_data_out = '0;
   assign mc_data_oe  = 1'b0;
`endif
endmodule

// File: tb/tb_mc_bus_bridge.sv
// tb_mc_bus_bridge: directed checks of mc_bus_bridge write FIFO, reset and readback behaviour.
module tb_mc_bus_bridge;
   logic        clock = 1'b0, reset = 1'b0;
   logic        mc_ce_n = 1'b1, mc_we_n = 1'b1, mc_oe_n = 1'b1;
   logic [5:0]  mc_add = '0;
   logic [15:0] mc_data_in = '0;
   logic [15:0] mc_data_out;
   logic        mc_data_oe, wr_valid, overflow;
   logic        wr_ready = 1'b0;
   logic [5:0]  wr_addr, rd_addr;
   logic [15:0] wr_data, rd_data;
   logic [2:0]  fifo_level;
   int          checks = 0, failures = 0;

   mc_bus_bridge dut (
      .clock(clock), .reset(reset), .mc_ce_n(mc_ce_n), .mc_we_n(mc_we_n), .mc_oe_n(mc_oe_n),
      .mc_add(mc_add), .mc_data_in(mc_data_in), .mc_data_out(mc_data_out), .mc_data_oe(mc_data_oe),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .fifo_level(fifo_level), .overflow(overflow)
   );

   always #5 clock = ~clock;
   always_comb rd_data = (rd_addr == 6'h05) ? 16'h00A5 : 16'h0000;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [5:0] a, input logic [15:0] d);
      mc_add = a; mc_data_in = d; mc_ce_n = 1'b0; mc_we_n = 1'b0;
      repeat (4) tick();
      mc_ce_n = 1'b1; mc_we_n = 1'b1;
      repeat (3) tick();
   endtask

   task automatic head(input string tag, input logic [5:0] a, input logic [15:0] d);
      check({tag, "_valid"}, 32'(wr_valid), 32'd1);
      check({tag, "_addr"}, 32'(wr_addr), 32'(a));
      check({tag, "_data"}, 32'(wr_data), 32'(d));
   endtask

   initial begin
      #1 reset = 1'b1;
      #1;
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_valid", 32'(wr_valid), 32'd0);
      check("rst_addr", 32'(wr_addr), 32'd0);
      check("rst_data", 32'(wr_data), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_doe", 32'(mc_data_oe), 32'd0);
      check("rst_dout", 32'(mc_data_out), 32'd0);
      check("rst_rdaddr", 32'(rd_addr), 32'd0);
      repeat (2) tick();
      reset = 1'b0;
      tick();
      // single write, 5-cycle strobe, consumer always ready
      wr_ready = 1'b1;
      mc_add = 6'h19; mc_data_in = 16'h0002; mc_ce_n = 1'b0; mc_we_n = 1'b0;
      tick();
      check("t1_k0_valid", 32'(wr_valid), 32'd0);
      tick();
      check("t1_k1_valid", 32'(wr_valid), 32'd0);
      tick();
      head("t1_k2", 6'h19, 16'h0002);
      check("t1_k2_level", 32'(fifo_level), 32'd1);
      tick();
      check("t1_k3_valid", 32'(wr_valid), 32'd0);
      check("t1_k3_level", 32'(fifo_level), 32'd0);
      tick();
      check("t1_k4_valid", 32'(wr_valid), 32'd0);
      mc_ce_n = 1'b1; mc_we_n = 1'b1;
      repeat (3) tick();
      check("t1_end_level", 32'(fifo_level), 32'd0);
      // back-pressure and overflow
      wr_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         wr(6'h19, 16'(i));
         check($sformatf("t2_level%0d", i), 32'(fifo_level), (i > 4) ? 32'd4 : 32'(i));
      end
      check("t2_ovf", 32'(overflow), 32'd1);
      wr_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         head($sformatf("t2_drain%0d", i), 6'h19, 16'(i));
         check($sformatf("t2_dlevel%0d", i), 32'(fifo_level), 32'(5 - i));
         tick();
      end
      check("t2_empty_valid", 32'(wr_valid), 32'd0);
      check("t2_ovf_sticky", 32'(overflow), 32'd1);
      wr_ready = 1'b0;
      // reset mid-operation with write strobe held across release
      wr(6'h01, 16'h000A);
      wr(6'h02, 16'h000B);
      wr(6'h03, 16'h000C);
      check("t3_level3", 32'(fifo_level), 32'd3);
      mc_add = 6'h2A; mc_data_in = 16'h0BEE; mc_ce_n = 1'b0; mc_we_n = 1'b0;
      reset = 1'b1;
      #1;
      check("t3_async_level", 32'(fifo_level), 32'd0);
      check("t3_async_valid", 32'(wr_valid), 32'd0);
      check("t3_async_ovf", 32'(overflow), 32'd0);
      tick();
      reset = 1'b0;
      repeat (5) tick();
      mc_ce_n = 1'b1; mc_we_n = 1'b1;
      repeat (3) tick();
      check("t3_one_push", 32'(fifo_level), 32'd1);
      head("t3_head", 6'h2A, 16'h0BEE);
      wr_ready = 1'b1;
      tick();
      check("t3_drained", 32'(fifo_level), 32'd0);
      wr_ready = 1'b0;
      // push and pop in the same cycle while full
      for (int i = 0; i < 4; i++) wr(6'(8'h11 + i), 16'(16'h0101 + i));
      check("t4_full", 32'(fifo_level), 32'd4);
      mc_add = 6'h15; mc_data_in = 16'h0105; mc_ce_n = 1'b0; mc_we_n = 1'b0;
      repeat (2) tick();
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      check("t4_level", 32'(fifo_level), 32'd4);
      check("t4_ovf", 32'(overflow), 32'd0);
      head("t4_head", 6'h12, 16'h0102);
      tick();
      mc_ce_n = 1'b1; mc_we_n = 1'b1;
      repeat (3) tick();
      check("t4_level_after", 32'(fifo_level), 32'd4);
      wr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         head($sformatf("t4_drain%0d", i), 6'(8'h12 + i), 16'(16'h0102 + i));
         tick();
      end
      check("t4_empty", 32'(fifo_level), 32'd0);
      wr_ready = 1'b0;
      // simultaneous we/oe counts as a write only
      mc_add = 6'h10; mc_data_in = 16'h1234; mc_ce_n = 1'b0; mc_we_n = 1'b0; mc_oe_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("t5_doe%0d", i), 32'(mc_data_oe), 32'd0);
      end
      mc_ce_n = 1'b1; mc_we_n = 1'b1; mc_oe_n = 1'b1;
      repeat (3) tick();
      check("t5_level", 32'(fifo_level), 32'd1);
      head("t5_head", 6'h10, 16'h1234);
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      // read strobe at 0x05
      mc_add = 6'h05; mc_ce_n = 1'b0; mc_oe_n = 1'b0;
`ifdef MC_READBACK_EN
      repeat (3) tick();
      check("t6_rdaddr", 32'(rd_addr), 32'h05);
      tick();
      check("t6_dout", 32'(mc_data_out), 32'h00A5);
      check("t6_doe", 32'(mc_data_oe), 32'd1);
      repeat (2) tick();
      check("t6_doe_hold", 32'(mc_data_oe), 32'd1);
      mc_ce_n = 1'b1; mc_oe_n = 1'b1;
      begin
         int n;
         n = 0;
         while (mc_data_oe && n < 3) begin
            tick();
            n++;
         end
         check("t6_doe_release", 32'(mc_data_oe), 32'd0);
      end
`else
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("t6_doe%0d", i), 32'(mc_data_oe), 32'd0);
      end
      check("t6_rdaddr_tied", 32'(rd_addr), 32'd0);
      check("t6_dout_tied", 32'(mc_data_out), 32'd0);
      mc_ce_n = 1'b1; mc_oe_n = 1'b1;
`endif
      repeat (3) tick();
      check("t6_no_push", 32'(fifo_level), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
